// File: rtl/lcd_write_sequencer.sv
// lcd_write_sequencer: HD44780 8-bit write-only sequencer.
// Power-up wait, init commands, then 4-char writes to line 1.
module lcd_write_sequencer #(
  parameter int E_HIGH_CYC       = 2,
  parameter int CMD_WAIT_CYC     = 40,
  parameter int CLEAR_WAIT_CYC   = 1640,
  parameter int POWERUP_WAIT_CYC = 15000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char1,
  input  logic [7:0] char2,
  input  logic [7:0] char3,
  input  logic [7:0] char4,
  input  logic       show,
  output logic       ready,
  output logic       done,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e
);

  localparam int M1 = (POWERUP_WAIT_CYC > CLEAR_WAIT_CYC) ?
                      POWERUP_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int M2 = (CMD_WAIT_CYC > E_HIGH_CYC) ?
                      CMD_WAIT_CYC : E_HIGH_CYC;
  localparam int MAXC = (M1 > M2) ? M1 : M2;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    S_PWR, S_INIT, S_IDLE, S_WRITE
  } main_e;

  typedef enum logic [1:0] {
    P_SETUP, P_EHIGH, P_HOLD, P_WAIT
  } phase_e;

  main_e          state_q, state_d;
  phase_e         phase_q, phase_d;
  logic [2:0]     idx_q, idx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    cur_q, cur_d;
  logic [31:0]    pend_q, pend_d;
  logic           pend_vld_q, pend_vld_d;
  logic           done_q, done_d;

  logic [7:0]     byte_d;
  logic           byte_rs;
  logic [CW-1:0]  wait_end;
  logic           last_byte;
  logic           start;

  assign wait_end = (state_q == S_INIT && idx_q == 3'd3) ?
                    CW'(CLEAR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
  assign last_byte = (state_q == S_INIT) ? (idx_q == 3'd3)
                                         : (idx_q == 3'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_PWR;
      phase_q    <= P_SETUP;
      idx_q      <= 3'd0;
      cnt_q      <= '0;
      cur_q      <= 32'h0;
      pend_q     <= 32'h0;
      pend_vld_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    done_d     = 1'b0;
    start      = 1'b0;
    if (show) begin
      pend_d     = {char1, char2, char3, char4};
      pend_vld_d = 1'b1;
    end
    unique case (state_q)
      S_PWR: begin
        if (cnt_q == CW'(POWERUP_WAIT_CYC - 1)) begin
          state_d = S_INIT;
          phase_d = P_SETUP;
          idx_d   = 3'd0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_IDLE: start = show;
      default: begin
        unique case (phase_q)
          P_SETUP: begin
            phase_d = P_EHIGH;
            cnt_d   = '0;
          end
          P_EHIGH: begin
            if (cnt_q == CW'(E_HIGH_CYC - 1)) begin
              phase_d = P_HOLD;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          P_HOLD: begin
            phase_d = P_WAIT;
            cnt_d   = '0;
          end
          default: begin
            if (cnt_q != wait_end) begin
              cnt_d = cnt_q + CW'(1);
            end else if (!last_byte) begin
              idx_d   = idx_q + 3'd1;
              phase_d = P_SETUP;
              cnt_d   = '0;
            end else begin
              done_d = (state_q == S_WRITE);
              if (show || pend_vld_q) begin
                start = 1'b1;
              end else begin
                state_d = S_IDLE;
                cnt_d   = '0;
              end
            end
          end
        endcase
      end
    endcase
    // A request arriving on the finishing edge is the newest, so it wins
    if (start) begin
      state_d    = S_WRITE;
      phase_d    = P_SETUP;
      idx_d      = 3'd0;
      cnt_d      = '0;
      cur_d      = show ? {char1, char2, char3, char4} : pend_q;
      pend_vld_d = 1'b0;
    end
  end

  always_comb begin
    byte_d  = 8'h00;
    byte_rs = 1'b0;
    if (state_q == S_INIT) begin
      unique case (idx_q)
        3'd0:    byte_d = 8'h38;
        3'd1:    byte_d = 8'h0C;
        3'd2:    byte_d = 8'h06;
        default: byte_d = 8'h01;
      endcase
    end else begin
      byte_rs = (idx_q != 3'd0);
      unique case (idx_q)
        3'd0:    byte_d = 8'h80;
        3'd1:    byte_d = cur_q[31:24];
        3'd2:    byte_d = cur_q[23:16];
        3'd3:    byte_d = cur_q[15:8];
        default: byte_d = cur_q[7:0];
      endcase
    end
  end

  always_comb begin
    logic busy;
    busy     = (state_q == S_INIT) || (state_q == S_WRITE);
    lcd_data = busy ? byte_d : 8'h00;
    lcd_rs   = busy && byte_rs;
    lcd_e    = busy && (phase_q == P_EHIGH);
    lcd_rw   = 1'b0;
    ready    = (state_q == S_IDLE) && !pend_vld_q;
    done     = done_q;
  end

endmodule

// File: doc/lcd_write_sequencer.md
# lcd_write_sequencer

Sequences a character LCD (HD44780-compatible, 8-bit bus, write-only) on behalf of the calculator.
- After reset it runs the power-up wait and the controller init command sequence.
- It then accepts four-character display requests from the calculator FSM through a `show`/`ready` handshake and writes each request to line 1, positions 0–3.
- It sits between `calculator_fsm` and the LCD pins, in the 1 MHz clock domain.
- One request is buffered while a transfer is in progress.

## Interface
- `E_HIGH_CYC`, 2: cycles `lcd_e` is held high per byte (≥1).
- `CMD_WAIT_CYC`, 40: wait cycles after every byte except clear (≥1).
- `CLEAR_WAIT_CYC`, 1640: wait cycles after the 0x01 clear command.
- `POWERUP_WAIT_CYC`, 15000: wait cycles after reset before the first init byte.
- `clk`  in  1  system clock (1 MHz in the calculator design).
- `rst`  in  1  reset, synchronous, active-high.
- `char1`..`char4`  in  8 each  ASCII characters, sampled when a request is captured.
- `show`  in  1  display request, single-cycle pulse.
- `ready`  out  1  high when idle with no pending request.
- `done`  out  1  one-cycle pulse when a request's fourth character finishes.
- `lcd_data`  out  8  LCD data bus.
- `lcd_rs`  out  1  0 = command, 1 = character data.
- `lcd_rw`  out  1  constant 0.
- `lcd_e`  out  1  LCD enable strobe.

## Operation
- **Main states:** PWR_WAIT → INIT → IDLE ↔ WRITE.
  - PWR_WAIT counts `POWERUP_WAIT_CYC` cycles.
  - INIT sends commands 0x38, 0x0C, 0x06, 0x01 in that order.
  - IDLE waits for a request.
  - WRITE sends command 0x80 (rs=0), then char1, char2, char3, char4 (rs=1).
- **Byte sub-sequence, identical for every byte:**
  - SETUP: 1 cycle; data and rs valid, e=0.
  - E_HIGH: `E_HIGH_CYC` cycles, e=1.
  - HOLD: 1 cycle; e=0, data and rs unchanged.
  - WAIT: `CLEAR_WAIT_CYC` cycles if the byte is command 0x01, otherwise `CMD_WAIT_CYC` cycles.
- `lcd_data` and `lcd_rs` stay unchanged from SETUP through WAIT.
- Outside a byte transfer, `lcd_data` is 0x00 and `lcd_rs` is 0.
- **Capture:**
  - `show`=1 on any edge captures char1..char4 into a request register. Later input changes are ignored.
  - In IDLE, the captured request starts immediately.
  - In PWR_WAIT, INIT or WRITE, the request goes to a single pending slot.
- **Pending slot:**
  - A new `show` while the slot is full overwrites it; the latest request wins and the earlier one is dropped without a `done`.
  - Leaving INIT, or finishing WRITE, with a pending request starts a new WRITE in the next cycle (SETUP of 0x80) and frees the slot.
- `ready` = (state == IDLE) and no pending request.
- `done` pulses exactly once per completed WRITE, never for INIT.
- **Reset at any cycle:**
  - Aborts the current transfer.
  - Clears the pending slot and all counters.
  - Returns to PWR_WAIT.

## Timing
- **Reset values:** `lcd_data`=0x00, `lcd_rs`=0, `lcd_rw`=0, `lcd_e`=0, `ready`=0, `done`=0.
- **Cycles per byte:** B = 2 + `E_HIGH_CYC` + wait. With defaults: 44 for a normal byte, 1644 for clear.
- **First SETUP** (lcd_data=0x38) is in cycle `POWERUP_WAIT_CYC` after rst deasserts. Cycle 0 is the first cycle with rst=0.
- **End of INIT:** INIT lasts 3×44 + 1644 = 1776 cycles. `ready` rises in the first cycle after the clear's WAIT ends.
- **Request from IDLE:**
  - `show` sampled high at edge T.
  - `ready`=0 and SETUP of 0x80 from cycle T+1.
- **Request completion:**
  - The request takes 5×B = 220 cycles with defaults.
  - `done`=1 in cycle T+221 for one cycle. `ready`=1 in that same cycle if nothing is pending.
  - If a request is pending, SETUP of the next 0x80 is in the same cycle as `done`.
- **Coincident events:**
  - `show` in the same cycle as `done`: treated as a new request from IDLE if `ready`=1 that cycle, otherwise it overwrites the pending slot.
  - `rst` dominates `show`.

## Test plan
- **Reset and init (override `POWERUP_WAIT_CYC`=20):** release rst → `lcd_e` rises first at cycle 21 with `lcd_data`=0x38, rs=0. Bytes 0x38, 0x0C, 0x06, 0x01 follow with 44/44/44/1644 spacing, then `ready`=1.
- **Single write:** chars "1","+","2","=" (0x31,0x2B,0x32,0x3D), `show` at T → bytes 0x80(rs=0), 0x31, 0x2B, 0x32, 0x3D (rs=1), each with e high for 2 cycles. `done` at T+221. Changing char inputs at T+5 has no effect.
- **Buffered request:** second `show` ("4567") at T+50 during a write → `ready` stays 0. Second WRITE's 0x80 SETUP in the `done` cycle at T+221. Second `done` at T+441.
- **Overwrite:** `show` "AAAA" at T+50, then "BBBB" at T+60 → only "BBBB" is written after the first request. Exactly two `done` pulses in total.
- **Show during init:** `show` "9999" during the clear WAIT → "9999" is written immediately after INIT. `ready` does not rise until that write's `done`.
- **Reset mid-write:** rst at T+100 → next cycle `lcd_e`=0, `lcd_data`=0x00, `ready`=0, pending cleared, no `done`. PWR_WAIT and INIT repeat.
